// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and sizing helpers for the FIFO read streamer.
package fifo_rd_stream_pkg;

  localparam int WIDTH_DATA_DEF = 36;
  localparam int RD_LATENCY_DEF = 1;

  // Skid buffer must absorb every read already issued plus one word being
  // presented and one word landing in the same cycle.
  function automatic int calc_buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  // Occupancy counters must be able to hold the value BUF_DEPTH itself.
  function automatic int calc_cnt_w(input int buf_depth);
    return $clog2(buf_depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_inflight.sv
// In-flight read tracker: one valid bit and one drop bit per outstanding read,
// shifted each cycle so the top bit lines up with the returning RAM word.
module rd_inflight_track #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             issue,
  input  logic             flush,
  output logic             ret_valid,
  output logic             ret_drop,
  output logic [CNT_W-1:0] inflight_total
);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] drop_q, drop_d;

  // Shift valid/drop bits; a flush marks every word still travelling as drop.
  // The word returning in the flush cycle itself is discarded by the top.
  always_comb begin
    vld_d     = '0;
    drop_d    = '0;
    vld_d[0]  = issue;
    drop_d[0] = 1'b0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      drop_d[i] = drop_q[i-1] | (flush & vld_q[i-1]);
    end
  end

  // Count all outstanding reads, dropped ones included, as buffer reservation.
  always_comb begin
    inflight_total = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_total = inflight_total + CNT_W'(vld_q[i]);
    end
  end

  assign ret_valid = vld_q[RD_LATENCY-1];
  assign ret_drop  = drop_q[RD_LATENCY-1];

  // Tracker state; reset forgets every read issued before it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_q  <= '0;
      drop_q <= '0;
    end else begin
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a non-show-ahead sync FIFO read port (fixed RAM latency) into a
// valid/ready stream via a small circular skid buffer.
// Handshake: a beat moves on every rising edge where m_valid && m_ready;
// m_valid never depends on m_ready and m_data holds while m_valid && !m_ready.
// Optional statistics outputs beat_cnt/drop_cnt: define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter  int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter  int RD_LATENCY = RD_LATENCY_DEF,
  localparam int BUF_DEPTH  = calc_buf_depth(RD_LATENCY),
  localparam int CNT_W      = calc_cnt_w(BUF_DEPTH),
  localparam int PTR_W      = $clog2(BUF_DEPTH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [WIDTH_DATA-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH_DATA-1:0] m_data,
  output logic [CNT_W-1:0]      buf_count
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int SUM_W = CNT_W + 1;

  logic [WIDTH_DATA-1:0] buf_q [BUF_DEPTH];
  logic [WIDTH_DATA-1:0] buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rst_done_q;
  logic                  ret_valid, ret_drop;
  logic [CNT_W-1:0]      inflight_total;
  logic [SUM_W-1:0]      occupancy;
  logic                  do_wr, do_xfer;

  rd_inflight_track #(
    .RD_LATENCY (RD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_track (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .issue          (fifo_ren),
    .flush          (flush),
    .ret_valid      (ret_valid),
    .ret_drop       (ret_drop),
    .inflight_total (inflight_total)
  );

  // Read issue uses only registered occupancy and fifo_empty (no m_ready path).
  always_comb begin
    occupancy = SUM_W'(count_q) + SUM_W'(inflight_total);
    fifo_ren  = rst_done_q & ~fifo_empty & ~flush & (occupancy < SUM_W'(BUF_DEPTH));
    do_wr     = ret_valid & ~ret_drop & ~flush;
    do_xfer   = m_valid & m_ready & ~flush;
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = buf_q[rptr_q];
  assign buf_count = count_q;

  // Pointer/count update with explicit wrap; flush empties the buffer.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    buf_d   = buf_q;
    if (do_wr) buf_d[wptr_q] = fifo_rdata;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_wr)   wptr_d = (wptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (do_xfer) rptr_d = (rptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      if (do_wr && !do_xfer)      count_d = count_q + CNT_W'(1);
      else if (!do_wr && do_xfer) count_d = count_q - CNT_W'(1);
    end
  end

  // Buffer, pointers and count; rst_done_q holds off reads until reset is gone.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rst_done_q <= 1'b1;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        do_drop;

  // Wrapping counters of delivered beats and discarded returning words.
  always_comb begin
    do_drop    = ret_valid & (ret_drop | flush);
    beat_cnt_d = beat_cnt_q + 32'(do_xfer);
    drop_cnt_d = drop_cnt_q + 16'(do_drop);
  end

  // Statistics registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  // Statistics build option off: no counters are present.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: three streamers (RD_LATENCY 1, 2, 3) each fed by a simple
// FIFO/RAM model whose word at read index i has the value i.
module tb_fifo_rd_stream;

  localparam int W = 36;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [2:0]   fifo_empty, fifo_ren, flush, m_valid, m_ready;
  logic [W-1:0] fifo_rdata [3];
  logic [W-1:0] m_data [3];
  logic [1:0]   buf_count0;
  logic [2:0]   buf_count1, buf_count2;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]  beat_cnt [3];
  logic [15:0]  drop_cnt [3];
`endif

  // ---------------- FIFO / RAM model ----------------
  int           rd_idx [3]  = '{0, 0, 0};
  int           n_words [3] = '{0, 0, 0};
  logic [W-1:0] pipe [3][3] = '{default: '0};

  always_comb begin
    fifo_empty = '1;
    for (int k = 0; k < 3; k++) fifo_empty[k] = (rd_idx[k] >= n_words[k]);
  end

  always @(posedge sys_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fifo_ren[k] && !fifo_empty[k]) begin
        pipe[k][0] <= W'(rd_idx[k]);
        rd_idx[k]  <= rd_idx[k] + 1;
      end
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign fifo_rdata[0] = pipe[0][0];
  assign fifo_rdata[1] = pipe[1][1];
  assign fifo_rdata[2] = pipe[2][2];

  // ---------------- DUTs ----------------
  fifo_rd_stream #(.WIDTH_DATA(W), .RD_LATENCY(1)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fifo_empty(fifo_empty[0]), .fifo_ren(fifo_ren[0]),
    .fifo_rdata(fifo_rdata[0]), .flush(flush[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .buf_count(buf_count0)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_cnt(beat_cnt[0]), .drop_cnt(drop_cnt[0])
`endif
  );

  fifo_rd_stream #(.WIDTH_DATA(W), .RD_LATENCY(2)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fifo_empty(fifo_empty[1]), .fifo_ren(fifo_ren[1]),
    .fifo_rdata(fifo_rdata[1]), .flush(flush[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .buf_count(buf_count1)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_cnt(beat_cnt[1]), .drop_cnt(drop_cnt[1])
`endif
  );

  fifo_rd_stream #(.WIDTH_DATA(W), .RD_LATENCY(3)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fifo_empty(fifo_empty[2]), .fifo_ren(fifo_ren[2]),
    .fifo_rdata(fifo_rdata[2]), .flush(flush[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_data(m_data[2]), .buf_count(buf_count2)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_cnt(beat_cnt[2]), .drop_cnt(drop_cnt[2])
`endif
  );

  // ---------------- monitor (negedge, inputs change at posedge+1) ----------------
  logic [W-1:0] got_q0 [$];
  logic [W-1:0] got_q1 [$];
  logic [W-1:0] got_q2 [$];
  int           beat_cyc0 [$];
  int           ren_cnt1 = 0;
  int           max_bc2  = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (m_valid[0] && m_ready[0] && !flush[0]) begin
        got_q0.push_back(m_data[0]);
        beat_cyc0.push_back(cyc);
      end
      if (m_valid[1] && m_ready[1] && !flush[1]) got_q1.push_back(m_data[1]);
      if (m_valid[2] && m_ready[2] && !flush[2]) got_q2.push_back(m_data[2]);
      if (fifo_ren[1]) ren_cnt1 <= ren_cnt1 + 1;
      if (int'(buf_count2) > max_bc2) max_bc2 <= int'(buf_count2);
    end
  end

  // ---------------- scoreboard / checker ----------------
  logic [W-1:0] exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Compare a received queue slice against exp_q.
  task automatic check_seq(input string tag, input int which, input int base);
    int n;
    logic [W-1:0] v;
    n = (which == 0) ? got_q0.size() : (which == 1) ? got_q1.size() : got_q2.size();
    check({tag, "_count"}, W'(n - base), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < n; i++) begin
      v = (which == 0) ? got_q0[base+i] : (which == 1) ? got_q1[base+i] : got_q2[base+i];
      check($sformatf("%s_beat%0d", tag, i), v, exp_q[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  int base, r1;

  initial begin
    sys_rst = 1'b1;
    flush   = '0;
    m_ready = '0;
    #1;
    check("rst_ren",   W'(fifo_ren), W'(0));
    check("rst_valid", W'(m_valid), W'(0));
    check("rst_data0", m_data[0], W'(0));
    check("rst_data2", m_data[2], W'(0));
    check("rst_bc",    W'({buf_count0, buf_count1, buf_count2}), W'(0));
    repeat (3) tick();
    sys_rst = 1'b0;
    repeat (2) tick();

    // A: latency 1, 8 words, m_ready high -> first beat 2 cycles after first read
    n_words[0] = 8;
    m_ready[0] = 1'b1;
    #1;
    check("a_ren_first", W'(fifo_ren[0]), W'(1));
    check("a_valid_c0",  W'(m_valid[0]), W'(0));
    tick();
    check("a_valid_c1",  W'(m_valid[0]), W'(0));
    tick();
    check("a_valid_c2",  W'(m_valid[0]), W'(1));
    check("a_data_c2",   m_data[0], W'(0));
    repeat (10) tick();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i));
    check_seq("a", 0, 0);
    if (beat_cyc0.size() >= 8) check("a_no_bubble", W'(beat_cyc0[7] - beat_cyc0[0]), W'(7));
    check("a_valid_end", W'(m_valid[0]), W'(0));
    check("a_ren_end",   W'(fifo_ren[0]), W'(0));

    // B: latency 2, m_ready low -> exactly 4 reads, buffer full, head stable
    r1 = ren_cnt1;
    n_words[1] = 8;
    repeat (10) tick();
    check("b_issues",  W'(ren_cnt1 - r1), W'(4));
    check("b_bc",      W'(buf_count1), W'(4));
    check("b_valid",   W'(m_valid[1]), W'(1));
    check("b_data",    m_data[1], W'(0));
    check("b_ren_off", W'(fifo_ren[1]), W'(0));
    tick();
    check("b_data_hold", m_data[1], W'(0));
    m_ready[1] = 1'b1;
    repeat (14) tick();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i));
    check_seq("b", 1, 0);

    // C: latency 3, m_ready toggling -> in order, no loss/dup, occupancy <= 5
    n_words[2] = 12;
    for (int i = 0; i < 40; i++) begin
      m_ready[2] = (i % 2 == 0);
      tick();
    end
    m_ready[2] = 1'b1;
    repeat (10) tick();
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(W'(i));
    check_seq("c", 2, 0);
    check("c_max_bc_le5", W'(max_bc2 <= 5), W'(1));

    // D: flush with 2 buffered (words 8,9) and word 10 returning
    base = got_q0.size();
    m_ready[0] = 1'b0;
    n_words[0] = 16;
    repeat (3) tick();
    check("d_bc_pre",    W'(buf_count0), W'(2));
    check("d_valid_pre", W'(m_valid[0]), W'(1));
    check("d_ren_full",  W'(fifo_ren[0]), W'(0));
    flush[0]   = 1'b1;
    m_ready[0] = 1'b1;
    #1;
    check("d_ren_flush", W'(fifo_ren[0]), W'(0));
    tick();
    flush[0] = 1'b0;
    #1;
    check("d_valid_post", W'(m_valid[0]), W'(0));
    check("d_bc_post",    W'(buf_count0), W'(0));
    check("d_ren_resume", W'(fifo_ren[0]), W'(1));
    repeat (10) tick();
    exp_q.delete();
    for (int i = 11; i < 16; i++) exp_q.push_back(W'(i));
    check_seq("d", 0, base);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("d_drop_cnt", W'(drop_cnt[0]), W'(1));
    check("d_beat_cnt", W'(beat_cnt[0]), W'(13));
`endif

    // E: latency 2, only 3 more words -> 3 reads, 3 beats, then idle
    base = got_q1.size();
    r1   = ren_cnt1;
    n_words[1] = 11;
    repeat (12) tick();
    check("e_issues", W'(ren_cnt1 - r1), W'(3));
    exp_q.delete();
    for (int i = 8; i < 11; i++) exp_q.push_back(W'(i));
    check_seq("e", 1, base);
    check("e_valid_end", W'(m_valid[1]), W'(0));
    check("e_ren_end",   W'(fifo_ren[1]), W'(0));
    check("e_bc_end",    W'(buf_count1), W'(0));

    // F: latency 3, reset with words 12 and 13 in flight
    base = got_q2.size();
    n_words[2] = 18;
    repeat (2) tick();
    sys_rst = 1'b1;
    #1;
    check("f_ren_rst",   W'(fifo_ren[2]), W'(0));
    check("f_valid_rst", W'(m_valid[2]), W'(0));
    check("f_data_rst",  m_data[2], W'(0));
    check("f_bc_rst",    W'(buf_count2), W'(0));
    tick();
    sys_rst = 1'b0;
    repeat (20) tick();
    exp_q.delete();
    for (int i = 14; i < 18; i++) exp_q.push_back(W'(i));
    check_seq("f", 2, base);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("f_beat_cnt", W'(beat_cnt[2]), W'(4));
    check("f_drop_cnt", W'(drop_cnt[2]), W'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
